// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan bus decoder; optional decimal point via SEG_SCAN_DP_EN
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     an,
`ifdef SEG_SCAN_DP_EN
    input  logic                      dp,
    output logic [NUM_DIGITS-1:0]     out_dp,
`endif
    output logic [4*NUM_DIGITS-1:0]   out_value,
    output logic [NUM_DIGITS-1:0]     out_bad,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_err,
    output logic                      drop
);

    localparam int SW = NUM_DIGITS + 8;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        SYNC,
        COLLECT
    } state_t;

    logic                    dp_in;
`ifdef SEG_SCAN_DP_EN
    assign dp_in = dp;
`else
    assign dp_in = 1'b1;
`endif

    logic [SW-1:0]           sample_q, prev_q;
    logic [7:0]              cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_bad_q, shadow_bad_d;
    logic [4*NUM_DIGITS-1:0] out_value_q, out_value_d;
    logic [NUM_DIGITS-1:0]   out_bad_q, out_bad_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    drop_q, drop_d;
    logic                    complete;

    logic [NUM_DIGITS-1:0]   an_s, sel;
    logic [6:0]              seg_s;
    logic                    an_ok, stable_ok, capture;
    logic [IW-1:0]           dig;
    logic [3:0]              nib;
    logic                    nib_bad;

    assign seg_s     = sample_q[6:0];
    assign an_s      = sample_q[7 +: NUM_DIGITS];
    assign sel       = ~an_s;
    assign an_ok     = (sel != '0) &&
                       ((sel & (sel - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == '0);
    assign stable_ok = (sample_q == prev_q) && an_ok;
    // Capture on the single increment that reaches the threshold; the counter then parks.
    assign capture   = stable_ok && (cnt_q == STABLE_M1);

    always_comb begin
        dig = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) dig = IW'(i);
        end
    end

    always_comb begin
        nib     = 4'h0;
        nib_bad = 1'b0;
        case (seg_s)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            7'b1111111: nib = 4'h0;
            default:    nib_bad = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!stable_ok)              cnt_d = 8'd0;
        else if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        shadow_val_d = shadow_val_q;
        shadow_bad_d = shadow_bad_q;
        frame_err_d  = 1'b0;
        complete     = 1'b0;
        if (capture) begin
            if (state_q == SYNC) begin
                if (dig == '0) begin
                    shadow_val_d[3:0] = nib;
                    shadow_bad_d[0]   = nib_bad;
                    mask_d            = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
                    state_d           = COLLECT;
                end
            end else begin
                shadow_val_d[{dig, 2'b00} +: 4] = nib;
                shadow_bad_d[dig]               = nib_bad;
                if (mask_q[dig]) begin
                    frame_err_d = 1'b1;
                    mask_d      = '0;
                end
                mask_d[dig] = 1'b1;
                if (&mask_d) begin
                    complete = 1'b1;
                    mask_d   = '0;
                end
            end
        end
    end

    always_comb begin
        out_value_d = out_value_q;
        out_bad_d   = out_bad_q;
        out_valid_d = out_valid_q;
        drop_d      = 1'b0;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_value_d = shadow_val_d;
                out_bad_d   = shadow_bad_d;
                out_valid_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q     <= '1;
            prev_q       <= '1;
            cnt_q        <= 8'd0;
            state_q      <= SYNC;
            mask_q       <= '0;
            shadow_val_q <= '0;
            shadow_bad_q <= '0;
            out_value_q  <= '0;
            out_bad_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            sample_q     <= {dp_in, an, seg};
            prev_q       <= sample_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            mask_q       <= mask_d;
            shadow_val_q <= shadow_val_d;
            shadow_bad_q <= shadow_bad_d;
            out_value_q  <= out_value_d;
            out_bad_q    <= out_bad_d;
            out_valid_q  <= out_valid_d;
            frame_err_q  <= frame_err_d;
            drop_q       <= drop_d;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, out_dp_q, out_dp_d;

    always_comb begin
        shadow_dp_d = shadow_dp_q;
        out_dp_d    = out_dp_q;
        if (capture && (state_q == COLLECT || dig == '0)) shadow_dp_d[dig] = sample_q[SW-1];
        if (complete && (!out_valid_q || out_ready))      out_dp_d         = shadow_dp_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_dp_q <= '0;
            out_dp_q    <= '0;
        end else begin
            shadow_dp_q <= shadow_dp_d;
            out_dp_q    <= out_dp_d;
        end
    end

    assign out_dp = out_dp_q;
`endif

    assign out_value = out_value_q;
    assign out_bad   = out_bad_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed vector bench for seg_scan_decoder
module tb_seg_scan_decoder;

    localparam int ND  = 4;
    localparam int SC  = 16;
    localparam int LAT = SC + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [4*ND-1:0] out_value;
    logic [ND-1:0] out_bad;
    logic          out_valid, out_ready, frame_err, drop;

    int n_vec = 0;
    int n_bad = 0;
    int ferr_cnt = 0, drop_cnt = 0, rise_cnt = 0;
    logic [15:0] rise_val;
    logic        vprev = 1'b0;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .out_value(out_value), .out_bad(out_bad), .out_valid(out_valid),
        .out_ready(out_ready), .frame_err(frame_err), .drop(drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (drop) drop_cnt++;
        if (out_valid && !vprev) begin
            rise_cnt++;
            rise_val = out_value;
        end
        vprev = out_valid;
    end

    typedef struct {
        logic [6:0]  s0, s1, s2, s3;
        logic [15:0] val;
        logic [3:0]  bad;
    } vec_t;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
    localparam logic [6:0] SCc = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic scan_digit(input int k, input logic [6:0] s, input int dwell,
                              output int rise_at, output logic [15:0] v, output logic [3:0] b);
        logic p;
        rise_at = -1;
        v = '0;
        b = '0;
        p = out_valid;
        an  = ~(4'b0001 << k);
        seg = s;
        for (int i = 1; i <= dwell; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid && !p && rise_at < 0) begin
                rise_at = i;
                v = out_value;
                b = out_bad;
            end
            p = out_valid;
        end
    endtask

    task automatic scan4(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                         input logic [6:0] a3, output int r, output logic [15:0] v,
                         output logic [3:0] b);
        scan_digit(0, a0, 20, r, v, b);
        scan_digit(1, a1, 20, r, v, b);
        scan_digit(2, a2, 20, r, v, b);
        scan_digit(3, a3, 20, r, v, b);
    endtask

    initial begin
        vec_t vecs[5];
        int r, c0, c1, c2;
        logic [15:0] v;
        logic [3:0] b;

        vecs[0] = '{s0: S4, s1: S3, s2: S2, s3: S1, val: 16'h1234, bad: 4'b0000};
        vecs[1] = '{s0: S0, s1: S5, s2: S6, s3: S7, val: 16'h7650, bad: 4'b0000};
        vecs[2] = '{s0: S8, s1: S9, s2: SA, s3: SB, val: 16'hBA98, bad: 4'b0000};
        vecs[3] = '{s0: SCc, s1: SD, s2: SE, s3: SF, val: 16'hFEDC, bad: 4'b0000};
        vecs[4] = '{s0: S5, s1: 7'b1111110, s2: S7, s3: 7'b1111111, val: 16'h0705, bad: 4'b0010};

        reset = 1'b1;
        an = '1;
        seg = '1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_value", 32'(out_value), 0);
        check("reset out_bad", 32'(out_bad), 0);
        check("reset frame_err/drop", {30'd0, frame_err, drop}, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            scan4(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, r, v, b);
            check($sformatf("vec%0d latency", i), 32'(r), LAT);
            check($sformatf("vec%0d value", i), 32'(v), 32'(vecs[i].val));
            check($sformatf("vec%0d bad", i), 32'(b), 32'(vecs[i].bad));
        end

        // Glitch: short dwell on digit 2 must not yield a frame.
        c0 = rise_cnt;
        scan_digit(0, S4, 20, r, v, b);
        scan_digit(1, S3, 20, r, v, b);
        scan_digit(2, S2, 10, r, v, b);
        scan_digit(3, S1, 20, r, v, b);
        check("glitch no frame", 32'(rise_cnt - c0), 0);
        scan4(S4, S3, S2, S1, r, v, b);
        check("glitch recover value", 32'(v), 32'h1234);
        check("glitch recover latency", 32'(r), LAT);

        // Repeated digit inside a frame.
        c0 = ferr_cnt;
        c1 = rise_cnt;
        scan_digit(0, S4, 20, r, v, b);
        scan_digit(1, S3, 20, r, v, b);
        scan4(S4, S3, S2, S1, r, v, b);
        check("frame_err pulses", 32'(ferr_cnt - c0), 1);
        check("frame_err frames", 32'(rise_cnt - c1), 1);
        check("frame_err value", 32'(rise_val), 32'h1234);

        // Backpressure over two frames.
        out_ready = 1'b0;
        c0 = drop_cnt;
        c1 = rise_cnt;
        scan4(S4, S3, S2, S1, r, v, b);
        scan4(S8, S7, S6, S5, r, v, b);
        check("bp drop pulses", 32'(drop_cnt - c0), 1);
        check("bp frames", 32'(rise_cnt - c1), 1);
        check("bp out_valid held", 32'(out_valid), 1);
        check("bp out_value held", 32'(out_value), 32'h1234);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp valid falls", 32'(out_valid), 0);

        // Reset in the middle of a frame.
        scan_digit(0, S9, 20, r, v, b);
        scan_digit(1, S9, 20, r, v, b);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset out_value", 32'(out_value), 0);
        check("midreset flags", {29'd0, out_valid, frame_err, drop}, 0);
        reset = 1'b0;
        c2 = rise_cnt;
        scan_digit(2, S9, 20, r, v, b);
        scan_digit(3, S9, 20, r, v, b);
        scan4(S4, S3, S2, S1, r, v, b);
        check("midreset frames", 32'(rise_cnt - c2), 1);
        check("midreset value", 32'(rise_val), 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Decoder for the multiplexed seven-segment display bus; it is the receive side of our hex-to-segment encoding.
- It watches the active-low segment lines and the digit-enable lines, and filters out scan transitions.
- Each stable digit pattern is decoded back to a 4-bit nibble and placed in its digit slot.
- A complete frame is presented as one value on a valid/ready interface. It is used for display loopback checking and for on-chip self-test of the calculator display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 16, consecutive identical samples required before a digit is captured (2..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- seg  input  7  active-low segments; bit6=g … bit0=a.
- an  input  NUM_DIGITS  active-low digit enables; digit k is selected when only bit k is 0.
- out_value  output  4*NUM_DIGITS  decoded frame; digit k is at bits [4k+3:4k].
- out_bad  output  NUM_DIGITS  per-digit flag: the pattern was not recognised.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.
- frame_err  output  1  one-cycle pulse: a digit repeated before the frame was complete.
- drop  output  1  one-cycle pulse: a completed frame was discarded because of backpressure.

Behaviour:
- Reset:
  - The input register is cleared to all-ones.
  - The stable counter is 0, the collect mask is 0, and the FSM is in SYNC.
  - out_value=0, out_bad=0, out_valid=0, frame_err=0, drop=0.
  - A reset asserted mid-frame discards all partial state.
- Input stage: {an, seg} is registered once. All later logic uses this registered sample.
- Stability filter:
  - The counter increments while the sample equals the previous sample and an is one-hot-low.
  - It resets to 0 on any change or on an invalid an (all-ones or more than one zero).
  - Capture fires exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES.
  - No further capture occurs until the sample changes.
- Decode table (seg → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7.
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F.
  - 1111111 (blank) decodes to 0 with bad=0.
  - Any other pattern decodes to 0 with bad=1.
- FSM SYNC:
  - Captures are ignored until a capture on digit 0 occurs.
  - That capture is stored in slot 0, sets mask bit 0, and moves the FSM to COLLECT.
- FSM COLLECT, capture on digit k:
  - If mask bit k is 0: write the shadow nibble and bad bit for slot k, then set mask bit k.
  - If mask bit k is already 1: pulse frame_err, clear the mask, then store k as the first digit of a new frame.
  - When the mask becomes all-ones, the frame completes in that cycle and the mask clears. The FSM stays in COLLECT.
- Output register, on frame completion:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: load out_value/out_bad from the shadow (including the digit just captured) on that edge, and set out_valid=1.
  - Otherwise: discard the frame, pulse drop, and leave the outputs unchanged.
- Handshake:
  - A transfer occurs when out_valid and out_ready are both 1 on an edge.
  - out_valid falls after a transfer unless a new frame loads on the same edge.
  - out_value and out_bad are held stable while out_valid=1.
- Latency: out_valid rises on the edge immediately after the capture cycle that completes the frame.

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- When defined:
  - Adds input dp (1 bit, active-low decimal point) and output out_dp (NUM_DIGITS).
  - dp is part of the registered sample and of the stability compare.
  - dp is captured per slot alongside the nibble and presented as out_dp.
- When undefined: the dp and out_dp ports do not exist, and behaviour is exactly as above.

Test Plan:
- Basic frame:
  - Stimulus: reset, then scan digits 0..3 showing 4,3,2,1 (an=1110 seg=0011001; 1101/0110000; 1011/0100100; 0111/1111001), each dwelling 20 cycles, out_ready=1.
  - Response: out_valid=1 one cycle after digit 3's capture, with out_value=16'h1234 and out_bad=0.
- Glitch rejection:
  - Stimulus: the digit 2 dwell is shortened to 10 cycles inside a scan.
  - Response: no capture for digit 2 and no frame. The next full scan completes normally and yields 16'h1234.
- Bad pattern and blank:
  - Stimulus: digit 1 shows seg=1111110 and digit 3 is blank (1111111).
  - Response: out_bad=4'b0010, nibble 1=0, nibble 3=0, out_valid=1.
- Frame error:
  - Stimulus: scan digits 0,1,0,1,2,3.
  - Response: frame_err pulses exactly once (on the second digit-0 capture), then one frame is delivered.
- Backpressure:
  - Stimulus: out_ready=0 through two complete frames (0x1234, then 0x5678).
  - Response: the first frame is held, drop pulses once, and out_value stays 16'h1234. Raising out_ready for one cycle drops out_valid.
- Reset mid-frame:
  - Stimulus: assert reset after digits 0 and 1 are captured, then run a full scan.
  - Response: all outputs are 0 during reset, and the first frame delivered is the complete post-reset scan.
